// File: rtl/bus_glue_fanout_pkg.sv
// Shared constants and read-tag layout for the fan-out bus glue.
package bus_glue_fanout_pkg;

   // Read value returned for accesses to a branch index that does not exist
   localparam logic [31:0] MISS_DATA_DEF = 32'hDEAD_0BAD;

   // Read tag layout, MSB down: {valid, hit, sel[selw-1:0]}
   function automatic int tag_w(input int selw);
      return selw + 2;
   endfunction

   function automatic int tag_hit_pos(input int selw);
      return selw;
   endfunction

   function automatic int tag_vld_pos(input int selw);
      return selw + 1;
   endfunction

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/bus_glue_rdpipe.sv
// Read tag delay line plus the registered return mux. The tag enters on the
// same edge as the branch read strobe and leaves when branch data is valid.
module bus_glue_rdpipe
   import bus_glue_fanout_pkg::*;
#(
   parameter int             NBR       = 4,
   parameter int             DW        = 32,
   parameter int             SELW      = 2,
   parameter int             BR_LAT    = 2,
   parameter logic [DW-1:0]  MISS_DATA = DW'(MISS_DATA_DEF)
) (
   input  logic              gb_clk_i,
   input  logic              gb_rst_ni,
   input  logic              rd_vld_i,
   input  logic              rd_hit_i,
   input  logic [SELW-1:0]   rd_sel_i,
   input  logic [NBR*DW-1:0] b_rdata_i,
   output logic [DW-1:0]     h_rdata_o,
   output logic              h_rvalid_o
);

   localparam int TW  = tag_w(SELW);
   localparam int HIT = tag_hit_pos(SELW);
   localparam int VLD = tag_vld_pos(SELW);

   logic [BR_LAT:0][TW-1:0] tag_q;
   logic [TW-1:0]           tag_in;
   logic [TW-1:0]           tag_ex;
   logic [DW-1:0]           mux_d;
   logic [DW-1:0]           rdata_q;
   logic                    rvalid_q;

   assign tag_in = {rd_vld_i, rd_hit_i, rd_sel_i};
   assign tag_ex = tag_q[BR_LAT];

   // Tag shift register: slot 0 aligns with b_rstb, slot BR_LAT with valid b_rdata
   always_ff @(posedge gb_clk_i or negedge gb_rst_ni) begin
      if (!gb_rst_ni) tag_q <= '0;
      else            tag_q <= {tag_q[BR_LAT-1:0], tag_in};
   end

   // Return mux: selected branch on a hit, fixed pattern on a miss
   always_comb begin
      mux_d = MISS_DATA;
      if (tag_ex[HIT])
         for (int i = 0; i < NBR; i++)
            if (tag_ex[SELW-1:0] == SELW'(i)) mux_d = b_rdata_i[i*DW +: DW];
   end

   // Host return register: data holds between reads, valid is a one-cycle pulse
   always_ff @(posedge gb_clk_i or negedge gb_rst_ni) begin
      if (!gb_rst_ni) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= tag_ex[VLD];
         if (tag_ex[VLD]) rdata_q <= mux_d;
      end
   end

   assign h_rdata_o  = rdata_q;
   assign h_rvalid_o = rvalid_q;

endmodule

// File: rtl/bus_glue_fanout.sv
// Registered host-to-N-branch bus bridge. Top address bits pick the branch,
// the rest is broadcast; unmapped branch accesses are counted and reads to
// them return a fixed pattern at the normal latency.
module bus_glue_fanout
   import bus_glue_fanout_pkg::*;
#(
   parameter int             AW        = 24,
   parameter int             DW        = 32,
   parameter int             NBR       = 4,
   parameter int             SELW      = 2,
   parameter int             BR_LAT    = 2,
   parameter int             REG_IN    = 1,
   parameter logic [DW-1:0]  MISS_DATA = DW'(MISS_DATA_DEF)
) (
   input  logic                      gb_clk,
   input  logic                      gb_rst_n,
   input  logic [AW-1:0]             h_addr,
   input  logic [DW-1:0]             h_wdata,
   input  logic                      h_wen,
   input  logic                      h_rstb,
   output logic [DW-1:0]             h_rdata,
   output logic                      h_rvalid,
   output logic [NBR*(AW-SELW)-1:0]  b_addr,
   output logic [NBR*DW-1:0]         b_wdata,
   output logic [NBR-1:0]            b_wen,
   output logic [NBR-1:0]            b_rstb,
   input  logic [NBR*DW-1:0]         b_rdata,
   output logic [15:0]               miss_count,
   input  logic                      miss_clr
);

   localparam int LAW = AW - SELW;
   // Every select code maps to a branch, so nothing can miss
   localparam bit ALL_MAPPED = (NBR == (1 << SELW)) && (clog2(NBR) == SELW);

   logic [AW-1:0]         addr_s;
   logic [DW-1:0]         wdata_s;
   logic                  wen_s, rstb_s, clr_s;
   logic [SELW-1:0]       sel;
   logic                  hit, miss;
   logic [NBR-1:0]        wen_d, rstb_d;
   logic [NBR*LAW-1:0]    b_addr_q;
   logic [NBR*DW-1:0]     b_wdata_q;
   logic [NBR-1:0]        b_wen_q, b_rstb_q;
   logic [15:0]           miss_q;

   // miss_clr travels with the host inputs so a clear and an access issued in
   // the same host cycle meet at the counter on the same edge.
   generate
      if (REG_IN != 0) begin : g_regin
         logic [AW-1:0] addr_q;
         logic [DW-1:0] wdata_q;
         logic          wen_q, rstb_q, clr_q;

         // Input capture stage
         always_ff @(posedge gb_clk or negedge gb_rst_n) begin
            if (!gb_rst_n) begin
               addr_q  <= '0;
               wdata_q <= '0;
               wen_q   <= 1'b0;
               rstb_q  <= 1'b0;
               clr_q   <= 1'b0;
            end else begin
               addr_q  <= h_addr;
               wdata_q <= h_wdata;
               wen_q   <= h_wen;
               rstb_q  <= h_rstb;
               clr_q   <= miss_clr;
            end
         end

         assign addr_s  = addr_q;
         assign wdata_s = wdata_q;
         assign wen_s   = wen_q;
         assign rstb_s  = rstb_q;
         assign clr_s   = clr_q;
      end else begin : g_comb
         assign addr_s  = h_addr;
         assign wdata_s = h_wdata;
         assign wen_s   = h_wen;
         assign rstb_s  = h_rstb;
         assign clr_s   = miss_clr;
      end
   endgenerate

   assign sel  = addr_s[AW-1 -: SELW];
   assign hit  = ALL_MAPPED || (int'(sel) < NBR);
   assign miss = (wen_s | rstb_s) & ~hit;

   // Strobe steering: only an existing branch matching sel can fire
   always_comb begin
      wen_d  = '0;
      rstb_d = '0;
      for (int i = 0; i < NBR; i++)
         if (int'(sel) == i) begin
            wen_d[i]  = wen_s;
            rstb_d[i] = rstb_s;
         end
   end

   // Branch stage: broadcast address/data, registered per-branch strobes
   always_ff @(posedge gb_clk or negedge gb_rst_n) begin
      if (!gb_rst_n) begin
         b_addr_q  <= '0;
         b_wdata_q <= '0;
         b_wen_q   <= '0;
         b_rstb_q  <= '0;
      end else begin
         b_addr_q  <= {NBR{addr_s[LAW-1:0]}};
         b_wdata_q <= {NBR{wdata_s}};
         b_wen_q   <= wen_d;
         b_rstb_q  <= rstb_d;
      end
   end

   // Saturating miss counter; clear beats a coincident increment
   always_ff @(posedge gb_clk or negedge gb_rst_n) begin
      if (!gb_rst_n)                      miss_q <= '0;
      else if (clr_s)                     miss_q <= '0;
      else if (miss && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
   end

   assign b_addr     = b_addr_q;
   assign b_wdata    = b_wdata_q;
   assign b_wen      = b_wen_q;
   assign b_rstb     = b_rstb_q;
   assign miss_count = miss_q;

   bus_glue_rdpipe #(
      .NBR       (NBR),
      .DW        (DW),
      .SELW      (SELW),
      .BR_LAT    (BR_LAT),
      .MISS_DATA (MISS_DATA)
   ) u_rdpipe (
      .gb_clk_i   (gb_clk),
      .gb_rst_ni  (gb_rst_n),
      .rd_vld_i   (rstb_s),
      .rd_hit_i   (hit),
      .rd_sel_i   (sel),
      .b_rdata_i  (b_rdata),
      .h_rdata_o  (h_rdata),
      .h_rvalid_o (h_rvalid)
   );

endmodule
